// File: rtl/cocomemjr_dat_fill.sv
// DAT fill engine: writes {task, slot} DAT entries for a task range, identity or constant pages.
// Build option DAT_FILL_EXT_EN: drives the high byte and _we_dat_h alongside the low byte.
module cocomemjr_dat_fill #(
  parameter int TASK_BITS = 12
) (
  input  logic                 e,
  input  logic                 _reset,
  input  logic                 start,
  input  logic [TASK_BITS-1:0] task_first,
  input  logic [TASK_BITS-1:0] task_last,
  input  logic                 fill_mode,
  input  logic [7:0]           fill_value,
  input  logic                 dat_gnt,
  output logic                 dat_req,
  output logic [TASK_BITS+2:0] address_dat,
  output logic [15:0]          data_dat_out,
  output logic                 _we_dat_l,
  output logic                 _we_dat_h,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  // state  | meaning
  // IDLE   | waiting for start
  // REQ    | requesting the DAT bus
  // SETUP  | address/data presented, strobes high
  // STROBE | write strobe low for one cycle
  // DONE   | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, REQ, SETUP, STROBE, DONE} state_t;

  state_t               state, state_nxt;
  logic [TASK_BITS-1:0] task_cur;
  logic [TASK_BITS-1:0] task_end;
  logic [2:0]           slot;
  logic                 mode_q;
  logic [7:0]           value_q;
  logic                 last_entry;
  logic                 strobe_act;
  logic [7:0]           data_lo;

  // End of range is found by compare so an all-ones task_last never wraps to task 0.
  assign last_entry = (slot == 3'd7) && (task_cur == task_end);

  always_ff @(posedge e) begin
    if (!_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (task_first > task_last) ? DONE : REQ;
      REQ:     if (dat_gnt) state_nxt = SETUP;
      SETUP:   state_nxt = dat_gnt ? STROBE : REQ;
      STROBE:  state_nxt = last_entry ? DONE : SETUP;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge e) begin
    if (!_reset) begin
      task_cur <= '0;
      task_end <= '0;
      slot     <= 3'd0;
      mode_q   <= 1'b0;
      value_q  <= 8'h00;
      err      <= 1'b0;
    end else if (state == IDLE && start) begin
      task_cur <= task_first;
      task_end <= task_last;
      slot     <= 3'd0;
      mode_q   <= fill_mode;
      value_q  <= fill_value;
      err      <= task_first > task_last;
    end else if (state == STROBE && !last_entry) begin
      slot <= slot + 3'd1;
      if (slot == 3'd7) task_cur <= task_cur + 1'b1;
    end
  end

  // Reset low during STROBE must keep the strobe from ever going low.
  assign strobe_act  = (state == STROBE) && _reset;
  assign data_lo     = mode_q ? value_q : {5'b00000, slot};
  assign address_dat = {task_cur, slot};
  assign dat_req     = (state == REQ);
  assign busy        = (state == REQ) || (state == SETUP) || (state == STROBE);
  assign done        = (state == DONE);
  assign _we_dat_l   = !strobe_act;

`ifdef DAT_FILL_EXT_EN
  assign _we_dat_h    = !strobe_act;
  assign data_dat_out = {(mode_q ? value_q : 8'h00), data_lo};
`else
  assign _we_dat_h    = 1'b1;
  assign data_dat_out = {8'h00, data_lo};
`endif

endmodule

// File: tb/tb_cocomemjr_dat_fill.sv
// Directed bench for cocomemjr_dat_fill; expectations adapt to DAT_FILL_EXT_EN.
module tb_cocomemjr_dat_fill;

`ifdef DAT_FILL_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic        e = 1'b0;
  logic        _reset;
  logic        start;
  logic [11:0] task_first;
  logic [11:0] task_last;
  logic        fill_mode;
  logic [7:0]  fill_value;
  logic        dat_gnt;
  logic        dat_req;
  logic [14:0] address_dat;
  logic [15:0] data_dat_out;
  logic        _we_dat_l;
  logic        _we_dat_h;
  logic        busy;
  logic        done;
  logic        err;

  cocomemjr_dat_fill dut (
    .e(e), ._reset(_reset), .start(start), .task_first(task_first), .task_last(task_last),
    .fill_mode(fill_mode), .fill_value(fill_value), .dat_gnt(dat_gnt), .dat_req(dat_req),
    .address_dat(address_dat), .data_dat_out(data_dat_out), ._we_dat_l(_we_dat_l),
    ._we_dat_h(_we_dat_h), .busy(busy), .done(done), .err(err)
  );

  always #5 e = ~e;

  int checks = 0;
  int errors = 0;

  logic [14:0] s_addr [16];
  logic [15:0] s_data [16];
  int          s_rel  [16];
  logic        s_weh  [16];
  int          n_str, n_nog, n_zero, n_done, done_rel;
  logic        busy_r1, err_r2, we_at_rst;
  logic [5:0]  snap_ctl;
  logic [14:0] snap_addr;
  logic [15:0] snap_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // poke bit0: extra start at rel 1, bit1: extra start at rel 18 (both must be ignored)
  task automatic run(input logic [11:0] f, input logic [11:0] l, input logic m,
                     input logic [7:0] v, input int drop_s, input int drop_n,
                     input int rst_rel, input int poke, input int budget);
    logic gnt_prev;
    @(posedge e); #2;
    task_first = f; task_last = l; fill_mode = m; fill_value = v;
    start = 1'b1; dat_gnt = 1'b1; _reset = 1'b1;
    n_str = 0; n_nog = 0; n_zero = 0; n_done = 0; done_rel = -1;
    busy_r1 = 1'bx; err_r2 = 1'bx; we_at_rst = 1'bx;
    gnt_prev = 1'b1;
    for (int rel = 0; rel < budget; rel++) begin
      if (rel > 0) begin
        @(posedge e); #2;
        start = (poke[0] && rel == 1) || (poke[1] && rel == 18);
        if (rel == 1) begin
          task_first = 12'h000; task_last = 12'h000; fill_mode = ~m; fill_value = 8'hA5;
        end
        dat_gnt = !(rel >= drop_s && rel < drop_s + drop_n);
        _reset  = (rel != rst_rel);
      end
      @(negedge e);
      if (!_we_dat_l) begin
        if (n_str < 16) begin
          s_addr[n_str] = address_dat; s_data[n_str] = data_dat_out;
          s_rel[n_str] = rel; s_weh[n_str] = _we_dat_h;
        end
        n_str++;
        if (!gnt_prev) n_nog++;
        if (address_dat == 15'h0000) n_zero++;
      end
      if (done) begin n_done++; done_rel = rel; end
      if (rel == 1) busy_r1 = busy;
      if (rel == 2) err_r2 = err;
      if (rel == rst_rel) we_at_rst = _we_dat_l;
      if (rel == rst_rel + 1) begin
        snap_ctl  = {dat_req, busy, done, err, _we_dat_l, _we_dat_h};
        snap_addr = address_dat;
        snap_data = data_dat_out;
      end
      gnt_prev = dat_gnt;
    end
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] hi;
    _reset = 1'b0; start = 1'b0; task_first = '0; task_last = '0;
    fill_mode = 1'b0; fill_value = 8'h00; dat_gnt = 1'b0;
    repeat (3) @(posedge e);
    @(negedge e);
    chk("rst_ctl", {26'd0, dat_req, busy, done, err, _we_dat_l, _we_dat_h}, 32'b000011);
    chk("rst_addr", {17'd0, address_dat}, 32'h0);
    chk("rst_data", {16'd0, data_dat_out}, 32'h0);

    // first > last: no strobes, error, done one cycle after start
    run(12'd5, 12'd4, 1'b0, 8'h00, 0, 0, -1, 1, 8);
    chk("err_nstr", n_str, 0);
    chk("err_done_rel", done_rel, 1);
    chk("err_ndone", n_done, 1);
    chk("err_flag", {31'd0, err_r2}, 1);

    // task 3 identity, full grant; also clears err
    run(12'd3, 12'd3, 1'b0, 8'h00, 0, 0, -1, 3, 24);
    chk("a_nstr", n_str, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a_addr%0d", i), {17'd0, s_addr[i]}, 32'h18 + i);
      chk($sformatf("a_data%0d", i), {16'd0, s_data[i]}, i);
      chk($sformatf("a_rel%0d", i), s_rel[i], 3 + 2 * i);
      chk($sformatf("a_weh%0d", i), {31'd0, s_weh[i]}, EXT ? 0 : 1);
    end
    chk("a_done_rel", done_rel, 18);
    chk("a_ndone", n_done, 1);
    chk("a_busy", {31'd0, busy_r1}, 1);
    chk("a_err_clr", {31'd0, err_r2}, 0);
    chk("a_nog", n_nog, 0);

    // last task all-ones, constant 0x3F: must stop by compare
    run(12'hFFF, 12'hFFF, 1'b1, 8'h3F, 0, 0, -1, 3, 24);
    hi = EXT ? 8'h3F : 8'h00;
    chk("c_nstr", n_str, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("c_addr%0d", i), {17'd0, s_addr[i]}, 32'h7FF8 + i);
      chk($sformatf("c_data%0d", i), {16'd0, s_data[i]}, {16'd0, hi, 8'h3F});
    end
    chk("c_zero", n_zero, 0);
    chk("c_done_rel", done_rel, 18);

    // grant dropped for 3 cycles in SETUP of entry 2
    run(12'd1, 12'd1, 1'b0, 8'h00, 6, 3, -1, 3, 26);
    chk("d_nstr", n_str, 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("d_addr%0d", i), {17'd0, s_addr[i]}, 32'h08 + i);
    chk("d_data2", {16'd0, s_data[2]}, 2);
    chk("d_rel2", s_rel[2], 11);
    chk("d_nog", n_nog, 0);
    chk("d_done_rel", done_rel, 22);

    // reset during STROBE of entry 4
    run(12'd2, 12'd2, 1'b0, 8'h00, 0, 0, 11, 0, 24);
    chk("e_we_at_rst", {31'd0, we_at_rst}, 1);
    chk("e_nstr", n_str, 4);
    chk("e_ndone", n_done, 0);
    chk("e_ctl", {26'd0, snap_ctl}, 32'b000011);
    chk("e_addr", {17'd0, snap_addr}, 0);
    chk("e_data", {16'd0, snap_data}, 0);

    // constant 0x12: high byte and high strobe depend on build
    run(12'h0A0, 12'h0A0, 1'b1, 8'h12, 0, 0, -1, 0, 24);
    chk("f_nstr", n_str, 8);
    chk("f_data0", {16'd0, s_data[0]}, EXT ? 32'h1212 : 32'h0012);
    chk("f_weh0", {31'd0, s_weh[0]}, EXT ? 0 : 1);
    chk("f_addr7", {17'd0, s_addr[7]}, 32'h507);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cocomemjr_dat_fill.md
COCOMEMJR_DAT_FILL -- requirements
Module: cocomemjr_dat_fill

Interface
REQ-001 SHALL have parameter TASK_BITS, default 12, task-number width; DAT address width is TASK_BITS+3.
REQ-002 SHALL have port e, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port _reset, input, 1; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port start, input, 1, single-cycle fill request.
REQ-005 SHALL have port task_first, input, TASK_BITS, first task to fill.
REQ-006 SHALL have port task_last, input, TASK_BITS, last task to fill (inclusive).
REQ-007 SHALL have port fill_mode, input, 1: 0 = identity, 1 = constant.
REQ-008 SHALL have port fill_value, input, 8, constant page for fill_mode=1.
REQ-009 SHALL have port dat_gnt, input, 1, DAT bus granted by MMU core.
REQ-010 SHALL have port dat_req, output, 1, DAT bus request.
REQ-011 SHALL have port address_dat, output, TASK_BITS+3, DAT RAM address {task, slot}.
REQ-012 SHALL have port data_dat_out, output, 16, DAT write data.
REQ-013 SHALL have ports _we_dat_l and _we_dat_h, outputs, 1 each, active-low byte write strobes.
REQ-014 SHALL have ports busy, output, 1, and done, output, 1 (one-cycle pulse).
REQ-015 SHALL have port err, output, 1, set on illegal range, cleared by next accepted start.

Function
REQ-016 States SHALL be IDLE, REQ, SETUP, STROBE, DONE.
REQ-017 IDLE: start=1 latches task_first, task_last, fill_mode, fill_value; goes to REQ, or DONE with err=1 if task_first > task_last.
REQ-018 start while busy=1 SHALL be ignored; latched inputs SHALL not change until DONE.
REQ-019 REQ: dat_req=1; dat_gnt=1 -> SETUP; otherwise stay.
REQ-020 SETUP: address_dat and data_dat_out valid, strobes high; next -> STROBE if dat_gnt=1, else REQ.
REQ-021 STROBE: _we_dat_l=0 for exactly one cycle, address/data held stable from SETUP; then advance.
REQ-022 Advance: slot 0..7 increments; at slot 7, task increments, slot = 0; after task_last slot 7 -> DONE, else SETUP.
REQ-023 Entry data: identity -> low byte {5'b0, slot}; constant -> low byte fill_value; high byte 8'h00.
REQ-024 Throughput SHALL be 2 cycles per entry while dat_gnt stays 1; start-to-first-strobe latency 3 cycles with dat_gnt held 1.
REQ-025 task_last = all-ones SHALL terminate by compare, never by counter wrap; no write to task 0 after.
REQ-026 dat_gnt drop in SETUP SHALL abandon that strobe and redo the same entry after re-grant; no strobe without dat_gnt in prior cycle.
REQ-027 DAT: done=1 one cycle, busy=0, dat_req=0; -> IDLE. busy=1 in REQ, SETUP, STROBE.
REQ-028 start coincident with DONE SHALL be ignored.

Reset
REQ-029 _reset=0 at a rising edge SHALL force IDLE, dat_req=0, busy=0, done=0, err=0, address_dat=0, data_dat_out=0, both strobes=1.
REQ-030 Reset mid-fill SHALL abort with no further strobe; a strobe in that cycle SHALL not be driven low.

Configuration
REQ-031 Macro DAT_FILL_EXT_EN defined: _we_dat_h pulses with _we_dat_l; high byte = 8'h00 (identity) or fill_value (constant).
REQ-032 DAT_FILL_EXT_EN undefined: _we_dat_h tied 1, data_dat_out[15:8] = 8'h00.

Verification
REQ-033 start, first=3, last=3, identity, gnt=1 -> 8 strobes at addr 0x18..0x1F, data 0x00..0x07, done at cycle 18.
REQ-034 first=5, last=4 -> no strobe, err=1, done one cycle after start.
REQ-035 first=last=0xFFF, constant 0x3F -> 8 strobes at 0x7FF8..0x7FFF, data 0x3F, no access to 0x0000.
REQ-036 gnt dropped 3 cycles in SETUP of entry 2 -> entry 2 written exactly once, total 8 strobes.
REQ-037 _reset=0 in STROBE of entry 4 -> strobe high that cycle, all outputs reset, no further writes.
REQ-038 DAT_FILL_EXT_EN defined, constant 0x12 -> _we_dat_h matches _we_dat_l, data_dat_out = 0x1212.
